nibbler_control_unit: RTL and testbench

//  Fetch/execute sequencer for the 4-bit Nibbler uP. Owns phase FF, 12-bit PC, instruction register and C/Z

---
 rtl/nibbler_control_unit_if.sv | 43 ++++
 rtl/nibbler_control_unit.sv | 188 ++++++++++++++++++
 tb/tb_nibbler_control_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/nibbler_control_unit_if.sv
// Nibbler control unit bus: ROM fetch, flag inputs and datapath controls.
// master = control unit, slave = ROM/datapath side.
interface nibbler_control_unit_if #(
  parameter int PC_W = 12
);
  logic            run;
  logic [7:0]      program_byte;
  logic            c_in;
  logic            z_in;
  logic            phase;
  logic [PC_W-1:0] pc;
  logic [3:0]      instr;
  logic [3:0]      oprnd;
  logic            c_flag;
  logic            z_flag;
  logic [PC_W-1:0] address_ram;
  logic [1:0]      alu_op;
  logic            acc_we;
  logic            oprnd_oe;
  logic            ram_cs;
  logic            ram_we;
  logic            alu_oe;
  logic            in_oe;
  logic            out_we;

  modport master (
    input  run, program_byte, c_in, z_in,
    output phase, pc, instr, oprnd,
    output c_flag, z_flag, address_ram,
    output alu_op, acc_we, oprnd_oe,
    output ram_cs, ram_we, alu_oe,
    output in_oe, out_we
  );

  modport slave (
    output run, program_byte, c_in, z_in,
    input  phase, pc, instr, oprnd,
    input  c_flag, z_flag, address_ram,
    input  alu_op, acc_we, oprnd_oe,
    input  ram_cs, ram_we, alu_oe,
    input  in_oe, out_we
  );
endinterface

// File: rtl/nibbler_control_unit.sv
// Nibbler fetch/execute sequencer: phase, PC, IR and C/Z flags,
// plus per-cycle datapath control decode.
module nibbler_control_unit #(
  parameter int              PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  nibbler_control_unit_if.master bus
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } phase_t;

  typedef enum logic [3:0] {
    OP_JC    = 4'h0, OP_JNC   = 4'h1,
    OP_CMPI  = 4'h2, OP_CMPM  = 4'h3,
    OP_LIT   = 4'h4, OP_IN    = 4'h5,
    OP_LD    = 4'h6, OP_ST    = 4'h7,
    OP_JZ    = 4'h8, OP_JNZ   = 4'h9,
    OP_ADDI  = 4'hA, OP_ADDM  = 4'hB,
    OP_JMP   = 4'hC, OP_OUT   = 4'hD,
    OP_NANDI = 4'hE, OP_NANDM = 4'hF
  } op_t;

  phase_t          state, state_nx;
  logic [PC_W-1:0] pc_q, pc_nx;
  logic [3:0]      instr_q, instr_nx;
  logic [3:0]      oprnd_q, oprnd_nx;
  logic            c_q, c_nx;
  logic            z_q, z_nx;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] addr;

  logic [1:0] alu_op;
  logic       acc_we;
  logic       oprnd_oe;
  logic       ram_cs;
  logic       ram_we;
  logic       alu_oe;
  logic       in_oe;
  logic       out_we;

  assign pc_inc = pc_q + PC_W'(1);
  assign addr   = PC_W'({oprnd_q, bus.program_byte});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      oprnd_q <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state   <= state_nx;
      pc_q    <= pc_nx;
      instr_q <= instr_nx;
      oprnd_q <= oprnd_nx;
      c_q     <= c_nx;
      z_q     <= z_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    instr_nx = instr_q;
    oprnd_nx = oprnd_q;
    c_nx     = c_q;
    z_nx     = z_q;
    alu_op   = 2'b00;
    acc_we   = 1'b0;
    oprnd_oe = 1'b0;
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    alu_oe   = 1'b0;
    in_oe    = 1'b0;
    out_we   = 1'b0;
    if (bus.run) begin
      unique case (state)
        FETCH: begin
          instr_nx = bus.program_byte[7:4];
          oprnd_nx = bus.program_byte[3:0];
          pc_nx    = pc_inc;
          state_nx = EXEC;
        end
        EXEC: begin
          state_nx = FETCH;
          // Two-byte ops default to skipping the address byte
          pc_nx    = pc_inc;
          unique case (instr_q)
            OP_JC:  if (c_q)  pc_nx = addr;
            OP_JNC: if (!c_q) pc_nx = addr;
            OP_JZ:  if (z_q)  pc_nx = addr;
            OP_JNZ: if (!z_q) pc_nx = addr;
            OP_JMP: pc_nx = addr;
            OP_CMPI: begin
              pc_nx    = pc_q;
              oprnd_oe = 1'b1;
              alu_op   = 2'b01;
              c_nx     = bus.c_in;
              z_nx     = bus.z_in;
            end
            OP_CMPM: begin
              ram_cs = 1'b1;
              alu_op = 2'b01;
              c_nx   = bus.c_in;
              z_nx   = bus.z_in;
            end
            OP_LIT: begin
              pc_nx    = pc_q;
              oprnd_oe = 1'b1;
              acc_we   = 1'b1;
            end
            OP_IN: begin
              pc_nx  = pc_q;
              in_oe  = 1'b1;
              acc_we = 1'b1;
            end
            OP_LD: begin
              ram_cs = 1'b1;
              acc_we = 1'b1;
            end
            OP_ST: begin
              alu_oe = 1'b1;
              ram_cs = 1'b1;
              ram_we = 1'b1;
            end
            OP_ADDI: begin
              pc_nx    = pc_q;
              oprnd_oe = 1'b1;
              acc_we   = 1'b1;
              alu_op   = 2'b10;
              c_nx     = bus.c_in;
              z_nx     = bus.z_in;
            end
            OP_ADDM: begin
              ram_cs = 1'b1;
              acc_we = 1'b1;
              alu_op = 2'b10;
              c_nx   = bus.c_in;
              z_nx   = bus.z_in;
            end
            OP_OUT: begin
              pc_nx  = pc_q;
              alu_oe = 1'b1;
              out_we = 1'b1;
            end
            OP_NANDI: begin
              pc_nx    = pc_q;
              oprnd_oe = 1'b1;
              acc_we   = 1'b1;
              alu_op   = 2'b11;
              z_nx     = bus.z_in;
            end
            OP_NANDM: begin
              ram_cs = 1'b1;
              acc_we = 1'b1;
              alu_op = 2'b11;
              z_nx   = bus.z_in;
            end
          endcase
        end
      endcase
    end
  end

  assign bus.phase       = state;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.oprnd       = oprnd_q;
  assign bus.c_flag      = c_q;
  assign bus.z_flag      = z_q;
  assign bus.address_ram = addr;
  assign bus.alu_op      = alu_op;
  assign bus.acc_we      = acc_we;
  assign bus.oprnd_oe    = oprnd_oe;
  assign bus.ram_cs      = ram_cs;
  assign bus.ram_we      = ram_we;
  assign bus.alu_oe      = alu_oe;
  assign bus.in_oe       = in_oe;
  assign bus.out_we      = out_we;

endmodule

// File: tb/tb_nibbler_control_unit.sv
// Random-program bench for nibbler_control_unit with an
// instruction-level reference model and a scoreboard queue.
module tb_nibbler_control_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] rom [4096];

  nibbler_control_unit_if #(.PC_W(12)) bus ();

  nibbler_control_unit #(
    .PC_W(12),
    .RESET_PC(12'h000)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.program_byte = rom[bus.pc];

  typedef logic [43:0] obs_t;
  obs_t q [$];
  int vectors = 0;
  int errors = 0;

  bit [11:0] m_pc;
  bit        m_exec;
  bit [3:0]  m_ir;
  bit [3:0]  m_op;
  bit        m_c;
  bit        m_z;

  // {alu_op, acc_we, oprnd_oe, ram_cs, ram_we, alu_oe, in_oe, out_we}
  function automatic logic [8:0] ctl(input bit [3:0] op);
    case (op)
      4'h2:    return {2'b01, 7'b0100000};
      4'h3:    return {2'b01, 7'b0010000};
      4'h4:    return {2'b00, 7'b1100000};
      4'h5:    return {2'b00, 7'b1000010};
      4'h6:    return {2'b00, 7'b1010000};
      4'h7:    return {2'b00, 7'b0011100};
      4'hA:    return {2'b10, 7'b1100000};
      4'hB:    return {2'b10, 7'b1010000};
      4'hD:    return {2'b00, 7'b0000101};
      4'hE:    return {2'b11, 7'b1100000};
      4'hF:    return {2'b11, 7'b1010000};
      default: return 9'd0;
    endcase
  endfunction

  function automatic bit one_byte(input bit [3:0] op);
    return op inside {4'h2, 4'h4, 4'h5, 4'hA, 4'hD, 4'hE};
  endfunction

  function automatic bit taken(input bit [3:0] op, input bit c, input bit z);
    case (op)
      4'h0:    return c;
      4'h1:    return !c;
      4'h8:    return z;
      4'h9:    return !z;
      4'hC:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 12'h000;
    m_exec = 1'b0;
    m_ir = 4'h0;
    m_op = 4'h0;
    m_c = 1'b0;
    m_z = 1'b0;
  endtask

  function automatic obs_t expect_now(input bit run);
    logic [8:0]  c;
    logic [11:0] a;
    a = {m_op, rom[m_pc]};
    c = (run && m_exec) ? ctl(m_ir) : 9'd0;
    return {m_exec, m_pc, m_ir, m_op, m_c, m_z, a, c};
  endfunction

  task automatic model_step(input bit cin, input bit zin);
    bit [11:0] a;
    if (!m_exec) begin
      {m_ir, m_op} = rom[m_pc];
      m_pc = m_pc + 12'd1;
      m_exec = 1'b1;
    end else begin
      a = {m_op, rom[m_pc]};
      if (m_ir inside {4'h2, 4'h3, 4'hA, 4'hB}) begin
        m_c = cin;
        m_z = zin;
      end else if (m_ir inside {4'hE, 4'hF}) begin
        m_z = zin;
      end
      if (taken(m_ir, m_c, m_z))
        m_pc = a;
      else if (!one_byte(m_ir))
        m_pc = m_pc + 12'd1;
      m_exec = 1'b0;
    end
  endtask

  initial begin
    obs_t got;
    obs_t exp;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        exp = q.pop_front();
        got = {bus.phase, bus.pc, bus.instr, bus.oprnd,
               bus.c_flag, bus.z_flag, bus.address_ram,
               bus.alu_op, bus.acc_we, bus.oprnd_oe,
               bus.ram_cs, bus.ram_we, bus.alu_oe,
               bus.in_oe, bus.out_we};
        vectors++;
        if (got !== exp) begin
          errors++;
          $display("FAIL outputs t=%0t got=%h expected=%h", $time, got, exp);
        end
      end
    end
  end

  initial begin
    bit r;
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    // JMP 0xFFF, then a JMP fetched at 0xFFF wraps the PC to 0x000
    rom[0] = 8'hCF;
    rom[1] = 8'hFF;
    rom[12'hFFF] = 8'hC0;
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.c_in = 1'b0;
    bus.z_in = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst_n = !(cyc < 2 || $urandom_range(0, 99) < 2);
      r = (cyc < 40) ? 1'b1 : ($urandom_range(0, 99) < 85);
      bus.run = r;
      bus.c_in = 1'($urandom);
      bus.z_in = 1'($urandom);
      if (!rst_n) model_reset();
      q.push_back(expect_now(r));
      if (rst_n && r) model_step(bus.c_in, bus.z_in);
    end
    repeat (3) @(negedge clk);
    #5;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
